// File: rtl/proc_control.sv
// proc_control: four-step (T0..T3) instruction sequencer for a simple bus-based processor.
// Outputs are decoded from the registered state and instruction register.
module proc_control (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic [15:0] DIN,
    output logic        IRin,
    output logic [7:0]  Rin,
    output logic [7:0]  Rout,
    output logic        DINout,
    output logic        Gout,
    output logic        Ain,
    output logic        Gin,
    output logic        soma,
    output logic        add_sub,
    output logic        zero,
    output logic        comparacao,
    output logic        maior_menor,
    output logic        Done
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    localparam logic [2:0] OP_MV = 3'd0, OP_MVI = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                           OP_MVNZ = 3'd4, OP_SEQ = 3'd5, OP_SLT = 3'd6;
    state_t      state_q, state_d;
    logic [15:0] ir_q;
    logic [2:0]  opcode;
    logic [7:0]  x_dec, y_dec;
    logic        alu;
    assign opcode = ir_q[15:13];
    assign x_dec  = 8'd1 << ir_q[12:10];
    assign y_dec  = 8'd1 << ir_q[9:7];
    assign alu    = opcode inside {[OP_ADD:OP_SLT]};
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (IRin) ir_q <= DIN;
        end
    end
    always_comb begin
        state_d     = state_q;
        IRin        = 1'b0;
        Rin         = '0;
        Rout        = '0;
        DINout      = 1'b0;
        Gout        = 1'b0;
        Ain         = 1'b0;
        Gin         = 1'b0;
        soma        = 1'b0;
        add_sub     = 1'b0;
        zero        = 1'b0;
        comparacao  = 1'b0;
        maior_menor = 1'b0;
        Done        = 1'b0;
        case (state_q)
            T0: begin
                // Gated by Resetn so nothing asserts while reset is held
                IRin    = Run & Resetn;
                state_d = Run ? T1 : T0;
            end
            T1: begin
                if (alu) begin
                    Rout    = x_dec;
                    Ain     = 1'b1;
                    state_d = T2;
                end else begin
                    Done    = 1'b1;
                    state_d = T0;
                    Rout    = (opcode == OP_MV) ? y_dec : '0;
                    DINout  = (opcode == OP_MVI);
                    Rin     = (opcode == OP_MV || opcode == OP_MVI) ? x_dec : '0;
                end
            end
            T2: begin
                Rout        = y_dec;
                Gin         = 1'b1;
                soma        = (opcode == OP_ADD) || (opcode == OP_SUB);
                add_sub     = (opcode == OP_SUB);
                zero        = (opcode == OP_MVNZ);
                comparacao  = (opcode == OP_SEQ);
                maior_menor = (opcode == OP_SLT);
                state_d     = T3;
            end
            T3: begin
                Gout    = 1'b1;
                Rin     = x_dec;
                Done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed checks of proc_control sequencing plus per-cycle output invariants.
module tb_proc_control;
    logic        Clock = 1'b0;
    logic        Resetn, Run;
    logic [15:0] DIN;
    logic        IRin, DINout, Gout, Ain, Gin, soma, add_sub, zero, comparacao, maior_menor, Done;
    logic [7:0]  Rin, Rout;
    int checks = 0;
    int errors = 0;
    localparam logic [4:0] S_ADD = 5'b10000, S_SUB = 5'b11000, S_NZ = 5'b00100,
                           S_SEQ = 5'b00010, S_SLT = 5'b00001;
    localparam logic [26:0] ZERO  = '0;
    localparam logic [26:0] FETCH = 27'h1 << 26;
    proc_control dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .IRin(IRin), .Rin(Rin),
        .Rout(Rout), .DINout(DINout), .Gout(Gout), .Ain(Ain), .Gin(Gin), .soma(soma),
        .add_sub(add_sub), .zero(zero), .comparacao(comparacao), .maior_menor(maior_menor),
        .Done(Done)
    );
    always #5 Clock = ~Clock;
    wire [26:0] outs = {IRin, Rin, Rout, DINout, Gout, Ain, Gin,
                        soma, add_sub, zero, comparacao, maior_menor, Done};
    function automatic logic [26:0] ex(logic irin, logic [7:0] rin, logic [7:0] rout,
                                       logic dinout, logic gout, logic ain, logic gin,
                                       logic [4:0] sel, logic done);
        return {irin, rin, rout, dinout, gout, ain, gin, sel, done};
    endfunction
    function automatic logic [15:0] enc(logic [2:0] op, logic [2:0] x, logic [2:0] y);
        return {op, x, y, 7'h55};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic invariants();
        check("bus_excl", 32'($countones({Rout, Gout, DINout}) <= 1), 1);
        check("rin_onehot", 32'($countones(Rin) <= 1), 1);
        check("sel_excl", 32'($countones({soma, zero, comparacao, maior_menor}) <= 1), 1);
        check("addsub_needs_soma", 32'(add_sub & ~soma), 0);
        check("sel_only_with_gin", 32'(|{soma, zero, comparacao, maior_menor} & ~Gin), 0);
        check("rin_only_with_done", 32'((|Rin) & ~Done), 0);
    endtask
    task automatic cyc(input string tag, input logic run, input logic [15:0] din,
                       input logic [26:0] exp);
        @(negedge Clock);
        Run = run;
        DIN = din;
        #1;
        check(tag, outs, exp);
        invariants();
    endtask
    task automatic alu_instr(input string tag, input logic [2:0] op, input logic [2:0] x,
                             input logic [2:0] y, input logic [4:0] sel);
        logic [7:0] xd, yd;
        xd = 8'd1 << x;
        yd = 8'd1 << y;
        cyc({tag, "_t0"}, 1'b1, enc(op, x, y), FETCH);
        cyc({tag, "_t1"}, 1'b0, 16'(($urandom)), ex(0, 8'h00, xd, 0, 0, 1, 0, 5'b0, 0));
        cyc({tag, "_t2"}, 1'b1, 16'(($urandom)), ex(0, 8'h00, yd, 0, 0, 0, 1, sel, 0));
        cyc({tag, "_t3"}, 1'b0, 16'(($urandom)), ex(0, xd, 8'h00, 0, 1, 0, 0, 5'b0, 1));
    endtask
    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 16'hFFFF;
        #3;
        check("reset_outputs", outs, ZERO);
        @(posedge Clock);
        #1;
        check("reset_outputs_clocked", outs, ZERO);
        @(negedge Clock);
        Run    = 1'b0;
        Resetn = 1'b1;
        cyc("idle", 1'b0, 16'h2C00, ZERO);
        // mvi R3 with immediate 0x00AA
        cyc("mvi_t0", 1'b1, 16'h2C00, FETCH);
        cyc("mvi_t1", 1'b0, 16'h00AA, ex(0, 8'h08, 8'h00, 1, 0, 0, 0, 5'b0, 1));
        cyc("idle2", 1'b0, 16'h6500, ZERO);
        // sub R1,R2
        cyc("sub_t0", 1'b1, 16'h6500, FETCH);
        cyc("sub_t1", 1'b1, 16'hFFFF, ex(0, 8'h00, 8'h02, 0, 0, 1, 0, 5'b0, 0));
        cyc("sub_t2", 1'b1, 16'h2C00, ex(0, 8'h00, 8'h04, 0, 0, 0, 1, S_SUB, 0));
        cyc("sub_t3", 1'b0, 16'h0000, ex(0, 8'h02, 8'h00, 0, 1, 0, 0, 5'b0, 1));
        alu_instr("seq", 3'd5, 3'd4, 3'd6, S_SEQ);
        alu_instr("slt", 3'd6, 3'd7, 3'd0, S_SLT);
        alu_instr("mvnz", 3'd4, 3'd2, 3'd5, S_NZ);
        alu_instr("add_same", 3'd2, 3'd5, 3'd5, S_ADD);
        cyc("nop_t0", 1'b1, enc(3'd7, 3'd1, 3'd2), FETCH);
        cyc("nop_t1", 1'b0, 16'h0000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 5'b0, 1));
        cyc("mv_same_t0", 1'b1, enc(3'd0, 3'd6, 3'd6), FETCH);
        cyc("mv_same_t1", 1'b0, 16'h0000, ex(0, 8'h40, 8'h40, 0, 0, 0, 0, 5'b0, 1));
        // back-to-back with Run held: mv R0,R7 / add R1,R5 / nop
        cyc("b2b_c1", 1'b1, enc(3'd0, 3'd0, 3'd7), FETCH);
        cyc("b2b_c2", 1'b1, enc(3'd2, 3'd1, 3'd5), ex(0, 8'h01, 8'h80, 0, 0, 0, 0, 5'b0, 1));
        cyc("b2b_c3", 1'b1, enc(3'd2, 3'd1, 3'd5), FETCH);
        cyc("b2b_c4", 1'b1, 16'hFFFF, ex(0, 8'h00, 8'h02, 0, 0, 1, 0, 5'b0, 0));
        cyc("b2b_c5", 1'b1, 16'hFFFF, ex(0, 8'h00, 8'h20, 0, 0, 0, 1, S_ADD, 0));
        cyc("b2b_c6", 1'b1, enc(3'd7, 3'd0, 3'd0), ex(0, 8'h02, 8'h00, 0, 1, 0, 0, 5'b0, 1));
        cyc("b2b_c7", 1'b1, enc(3'd7, 3'd0, 3'd0), FETCH);
        cyc("b2b_c8", 1'b0, 16'h0000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 5'b0, 1));
        cyc("b2b_idle", 1'b0, 16'h0000, ZERO);
        // add R6,R1 aborted by reset during T2
        cyc("abort_t0", 1'b1, enc(3'd2, 3'd6, 3'd1), FETCH);
        cyc("abort_t1", 1'b1, 16'h0000, ex(0, 8'h00, 8'h40, 0, 0, 1, 0, 5'b0, 0));
        cyc("abort_t2", 1'b1, 16'h0000, ex(0, 8'h00, 8'h02, 0, 0, 0, 1, S_ADD, 0));
        #2;
        Resetn = 1'b0;
        #1;
        check("abort_async_zero", outs, ZERO);
        @(posedge Clock);
        #1;
        check("abort_no_t3", outs, ZERO);
        @(negedge Clock);
        Run    = 1'b0;
        Resetn = 1'b1;
        #1;
        check("abort_released_idle", outs, ZERO);
        cyc("post_mvi_t0", 1'b1, enc(3'd1, 3'd2, 3'd0), FETCH);
        cyc("post_mvi_t1", 1'b0, 16'h1234, ex(0, 8'h04, 8'h00, 1, 0, 0, 0, 5'b0, 1));
        for (int i = 0; i < 300; i++) begin
            @(negedge Clock);
            Run = ($urandom_range(0, 3) != 0);
            DIN = 16'($urandom);
            #1;
            invariants();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
